posit_encoder_pipe: RTL
=======================

// Module: posit_encoder_pipe
// PURPOSE
// - Pipelined posit encoder: packs an unpacked value (sign, scale, fraction) into an N-bit posit.
// - Rounds to nearest, ties to even.
// - Inverse of the posit field decoder. Sits at the back end of the Posit_Adder datapath,
//   ahead of the sequential multiply/accumulate units.
// - Valid/ready on both sides so stalls propagate upstream.
// PARAMETERS
// - N   32           posit width
// - ES  4            exponent field width
// - FW  N            input fraction width (hidden bit excluded; MSB has weight 1/2)
// - SW  $clog2(N)+ES+2  signed scale width
// PORTS
// - Clock      in   1    system clock, rising edge
// - Reset      in   1    asynchronous, active-high reset
// - InValid    in   1    input fields valid
// - InReady    out  1    encoder can accept this cycle
// - InNaR      in   1    value is NaR (priority over InZero)
// - InZero     in   1    value is exact zero
// - InSign     in   1    1 = negative
// - InScale    in   SW   signed power-of-two exponent, value = 2^InScale * 1.InFrac
// - InFrac     in   FW   fraction bits below the hidden 1
// - InSticky   in   1    OR of any discarded bits below InFrac
// - OutValid   out  1    OUT holds a result
// - OutReady   in   1    consumer takes OUT this cycle
// - OUT        out  N    encoded posit, two's complement when negative
// BEHAVIOUR
// - Reset (async assert, sync release): both stage valid bits = 0, OutValid = 0,
//   OUT = '0, InReady = 1 after release.
// - Latency: 2 cycles from an accepted input to OutValid. One result per cycle at full rate.
// - Accept when InValid && InReady. Per stage, advance = !valid_next || ready_next.
// - InReady = S1 can advance (combinational from OutReady). No bubble is needed to resume.
// - OUT and OutValid hold stable while OutValid && !OutReady. No drop, no duplication.
// - S1 (decompose):
//   - k = InScale >>> ES; e = InScale[ES-1:0].
//   - k >= 0: regime = (k+1) ones then a 0. k < 0: regime = -k zeros then a 1.
//   - Build the 2N-bit magnitude string {regime, e, InFrac}. Shift right by the regime length.
//   - Register the top N-1 bits, guard bit and sticky (shifted-out bits OR InSticky).
//   - Register sign and special flags.
// - S2 (round and pack):
//   - lsb = mag[0]. Round up if guard && (lsb || sticky).
//   - Clamp: k > N-2, or a rounding carry beyond maxpos, gives magnitude 2^(N-1)-1 (maxpos).
//   - Clamp: k < -(N-2) gives minpos (magnitude 1).
//   - Nonzero inputs never encode as 0 or NaR.
//   - Negative: OUT = -{1'b0, mag}.
//   - NaR: OUT = {1'b1, {N-1{1'b0}}}. Zero: OUT = '0. Fields are ignored in both cases.
// - Simultaneous accept and S2 drain in the same cycle is legal. Both stages shift.
// - Reset mid-operation: in-flight results are discarded and never presented.
// - Width rules:
//   - All shifts are on the 2N-bit string.
//   - Scale is sign-extended internally to SW+1 so k+1 cannot overflow.
//   - The rounding add is done at N bits and its carry is checked for the maxpos clamp.
// STRUCTURE
// - posit_pkg: N/ES defaults, NAR and ZERO constants, maxpos/minpos functions,
//   and a struct posit_unpacked_t {nar, zero, sign, scale, frac, sticky}.
// - The decoder shares this struct.
// - One sub-module, posit_round_pack: the S2 combinational round/clamp/negate,
//   reused by the future multiplier.
// - Pipeline registers and handshake stay in the top module.
// TESTING (N=32, ES=4, OutReady=1 unless stated)
// - T1 one:
//   - Scale=0, Frac=0 -> OUT=32'h4000_0000 two cycles after accept.
//   - Same with Sign=1 -> 32'hC000_0000.
// - T2 regimes:
//   - Scale=16 -> 32'h6000_0000.
//   - Scale=-1 -> 32'h3E00_0000.
//   - Scale=0, Frac=32'h8000_0000 -> 32'h4100_0000.
// - T3 rounding (Scale=0):
//   - Frac=32'h0000_0040, Sticky=0 -> 32'h4000_0000 (tie to even).
//   - Same with Sticky=1 -> 32'h4000_0001.
//   - Frac=32'h0000_00C0 -> 32'h4000_0002.
// - T4 saturation/specials:
//   - Scale=600 -> 32'h7FFF_FFFF.
//   - Scale=-600 -> 32'h0000_0001.
//   - Scale=-600, Sign=1 -> 32'hFFFF_FFFF.
//   - NaR with Zero also set -> 32'h8000_0000.
//   - Zero -> 32'h0.
// - T5 backpressure:
//   - Stream 4 values, hold OutReady=0 for 3 cycles.
//   - InReady drops after 2 accepts. OUT stays stable.
//   - All 4 results emerge in order after release.
// - T6 reset mid-stream:
//   - Assert Reset with 2 values in flight.
//   - OutValid=0 and OUT=0 immediately (async).
//   - No stale results after release.
//   - First new input appears after exactly 2 cycles.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit constants, saturation helpers and the unpacked-value struct
// used by both the encoder and the field decoder.
package posit_pkg;

    localparam int POSIT_N  = 32;
    localparam int POSIT_ES = 4;
    localparam int POSIT_FW = POSIT_N;
    localparam int POSIT_SW = $clog2(POSIT_N) + POSIT_ES + 2;

    localparam logic [POSIT_N-1:0] NAR  = {1'b1, {(POSIT_N-1){1'b0}}};
    localparam logic [POSIT_N-1:0] ZERO = '0;

    // Magnitudes exclude the sign bit.
    function automatic logic [POSIT_N-2:0] maxpos();
        return '1;
    endfunction

    function automatic logic [POSIT_N-2:0] minpos();
        return {{(POSIT_N-2){1'b0}}, 1'b1};
    endfunction

    typedef struct packed {
        logic                       nar;
        logic                       zero;
        logic                       sign;
        logic signed [POSIT_SW-1:0] scale;
        logic [POSIT_FW-1:0]        frac;
        logic                       sticky;
    } posit_unpacked_t;

endpackage

// File: rtl/posit_round_pack.sv
// Round-to-nearest-even, saturate and two's-complement a posit magnitude.
// Purely combinational so the multiplier can drop it into its own last stage.
module posit_round_pack
    import posit_pkg::*;
#(
    parameter int N = POSIT_N
) (
    input  logic         nar,
    input  logic         zero,
    input  logic         sign,
    input  logic         clamp_hi,
    input  logic         clamp_lo,
    input  logic [N-2:0] mag,
    input  logic         guard,
    input  logic         sticky,
    output logic [N-1:0] out
);

    logic         rnd;
    logic [N-1:0] sum;
    logic [N-2:0] res;

    always_comb begin
        rnd = guard & (mag[0] | sticky);
        sum = {1'b0, mag} + {{(N-1){1'b0}}, rnd};
        // A carry into bit N-1 means rounding overflowed past maxpos.
        if (clamp_lo)
            res = (N-1)'(minpos());
        else if (clamp_hi || sum[N-1])
            res = (N-1)'(maxpos());
        else
            res = sum[N-2:0];
        out = sign ? -{1'b0, res} : {1'b0, res};
        if (zero) out = N'(ZERO);
        if (nar)  out = N'(NAR);
    end

endmodule

// File: rtl/posit_encoder_pipe.sv
// Two-stage posit encoder: S1 lays out regime/exponent/fraction on a 2N-bit
// string, S2 rounds and packs. Valid/ready backpressure on both sides.
module posit_encoder_pipe
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES,
    parameter int FW = N,
    parameter int SW = $clog2(N) + ES + 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic                 InNaR,
    input  logic                 InZero,
    input  logic                 InSign,
    input  logic signed [SW-1:0] InScale,
    input  logic [FW-1:0]        InFrac,
    input  logic                 InSticky,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [N-1:0]         OUT
);

    localparam int STAGES = 2;
    localparam int BW     = ES + FW;
    localparam int RLW    = $clog2(N) + 1;
    localparam logic signed [SW:0] KMAX = (SW+1)'(N-2);
    localparam logic signed [SW:0] KMIN = -KMAX;
    localparam logic [2*N-1:0]     MSB1 = {1'b1, {(2*N-1){1'b0}}};
    localparam logic [2*N-1:0]     ALL1 = '1;

    typedef struct packed {
        logic         nar;
        logic         zero;
        logic         sign;
        logic         hi;
        logic         lo;
        logic [N-2:0] mag;
        logic         guard;
        logic         sticky;
    } s1_t;

    posit_unpacked_t  in_u;
    s1_t              s1_d, s1_q;
    logic [STAGES:1]  vld_pipe;
    logic             adv1, adv2;
    logic [N-1:0]     pack_out;

    logic signed [SW:0] kk;
    logic [RLW-1:0]     rl;
    logic [BW-1:0]      body;
    logic [2*N-1:0]     shifted, regime, str;
    logic               extra;

    assign in_u = '{nar: InNaR, zero: InZero, sign: InSign, scale: InScale,
                    frac: InFrac, sticky: InSticky};

    assign adv2     = !vld_pipe[2] || OutReady;
    assign adv1     = !vld_pipe[1] || adv2;
    assign InReady  = adv1;
    assign OutValid = vld_pipe[STAGES];

    always_comb begin
        s1_d = '0;
        // Extra sign bit keeps k+2 / 1-k from wrapping at the scale extremes.
        kk   = $signed({in_u.scale[SW-1], in_u.scale}) >>> ES;
        s1_d.hi = kk > KMAX;
        s1_d.lo = kk < KMIN;
        if (s1_d.hi || s1_d.lo)
            rl = RLW'(N);
        else
            rl = kk[SW] ? (RLW'(1) - kk[RLW-1:0]) : (kk[RLW-1:0] + RLW'(2));
        // Only the top N body bits can reach mag/guard; the rest fold into sticky.
        body    = {in_u.scale[ES-1:0], in_u.frac};
        extra   = |body[BW-N-1:0];
        shifted = {body[BW-1 -: N], {N{1'b0}}} >> rl;
        regime  = kk[SW] ? (MSB1 >> (rl - RLW'(1))) : ~(ALL1 >> (rl - RLW'(1)));
        str     = shifted | regime;
        s1_d.mag    = str[2*N-1 -: N-1];
        s1_d.guard  = str[N];
        s1_d.sticky = |str[N-1:0] | extra | in_u.sticky;
        s1_d.nar    = in_u.nar;
        s1_d.zero   = in_u.zero;
        s1_d.sign   = in_u.sign;
    end

    posit_round_pack #(.N(N)) u_round_pack (
        .nar      (s1_q.nar),
        .zero     (s1_q.zero),
        .sign     (s1_q.sign),
        .clamp_hi (s1_q.hi),
        .clamp_lo (s1_q.lo),
        .mag      (s1_q.mag),
        .guard    (s1_q.guard),
        .sticky   (s1_q.sticky),
        .out      (pack_out)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            OUT      <= '0;
        end else begin
            if (adv1) begin
                vld_pipe[1] <= InValid;
                if (InValid) s1_q <= s1_d;
            end
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) OUT <= pack_out;
            end
        end
    end

endmodule
